// File: rtl/bitty_exec_unit.sv
// ----------------------------------------------------------------------------
// bitty_exec_unit
//
// Multi-cycle execution unit: one instruction at a time walks
// IDLE -> LOAD -> CALC -> STORE -> DONE -> IDLE.  Operands are read from a
// small register file in LOAD, the ALU result is registered into d_out in
// CALC, written back in STORE and reported by a one-cycle done pulse.
//
// Instruction word (IW = 2*RW+10 bits):
//   rx  = instr[IW-1 -: RW]     destination / operand A register
//   ry  = next RW bits          operand B register (fmt 00)
//   imm = instr[IW-RW-1:5]      zero-extended immediate (fmt 01), overlaps ry
//   sel = instr[4:2]            ALU operation
//   fmt = instr[1:0]            00 reg, 01 imm, 10/11 illegal
//
// Handshake: an instruction is taken on a rising edge where
// instr_valid && instr_ready; instr_ready is high only in IDLE, so nothing
// else is accepted until the current instruction has finished.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   instr          instruction word
//   instr_valid    instruction present
//   instr_ready    unit is idle and can accept
//   stall          freezes the unit while in LOAD or CALC
//   done           one-cycle completion pulse
//   err            one-cycle illegal-format pulse, coincident with done
//   d_out          last ALU result
//   dbg_addr       register-file debug read index
//   dbg_data       combinational R[dbg_addr]
//   retired        saturating count of written-back instructions
//   dbg_state      current FSM state, for observation
// ----------------------------------------------------------------------------
module bitty_exec_unit #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int RW    = $clog2(NREGS),
    localparam int IW    = 2*RW + 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] d_out,
    input  logic [RW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       retired,
    output logic [2:0]        dbg_state
);

    localparam int SHW   = $clog2(DATA_W);
    localparam int IMM_W = IW - RW - 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CALC  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic [15:0]         retired_q, retired_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    // Field decode of the latched instruction.
    logic [RW-1:0]       rx;
    logic [RW-1:0]       ry;
    logic [IMM_W-1:0]    imm;
    logic [2:0]          sel;
    logic [1:0]          fmt;
    logic                fmt_illegal;
    logic [DATA_W-1:0]   alu_res;

    assign rx          = instr_q[IW-1 -: RW];
    assign ry          = instr_q[IW-RW-1 -: RW];
    assign imm         = instr_q[IW-RW-1:5];
    assign sel         = instr_q[4:2];
    assign fmt         = instr_q[1:0];
    assign fmt_illegal = fmt[1];

    // ALU on the operands captured in LOAD.
    always_comb begin
        alu_res = '0;
        case (sel)
            3'd0: alu_res = a_q + b_q;
            3'd1: alu_res = a_q - b_q;
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = a_q << b_q[SHW-1:0];
            3'd6: alu_res = a_q >> b_q[SHW-1:0];
            default: begin
                if (a_q == b_q)     alu_res = '0;
                else if (a_q > b_q) alu_res = DATA_W'(1);
                else                alu_res = DATA_W'(2);
            end
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        d_out_d   = d_out_q;
        retired_d = retired_q;
        regs_d    = regs_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!stall) begin
                    a_d     = regs_q[rx];
                    b_d     = (fmt == 2'b01) ? DATA_W'(imm) : regs_q[ry];
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!stall) begin
                    // Illegal formats still pass through CALC but report zero.
                    d_out_d = fmt_illegal ? '0 : alu_res;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (!fmt_illegal) begin
                    regs_d[rx] = d_out_q;
                    if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_out_q   <= '0;
            retired_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_out_q   <= d_out_d;
            retired_q <= retired_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_DONE) && fmt_illegal;
    assign d_out       = d_out_q;
    assign dbg_data    = regs_q[dbg_addr];
    assign retired     = retired_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bitty_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_bitty_exec_unit
//
// Directed bench for bitty_exec_unit at default parameters
// (DATA_W=16, NREGS=8, IW=16).  Expected values are hand-computed from the
// instruction encodings noted beside each step.
// ----------------------------------------------------------------------------
module tb_bitty_exec_unit;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int RW     = 3;
    localparam int IW     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [IW-1:0]     instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic              stall = 1'b0;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] d_out;
    logic [RW-1:0]     dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       retired;
    logic [2:0]        dbg_state;

    int tests = 0;
    int fails = 0;

    bitty_exec_unit #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .done        (done),
        .err         (err),
        .d_out       (d_out),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .retired     (retired),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- comparison ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Presents one instruction, holds stall high for the first n_stall cycles
    // after the accept edge, and returns at the falling edge where done is
    // seen (lat = cycles after accept, -1 if done never came).
    task automatic issue(input logic [15:0] word, input int n_stall,
                         output int lat, output logic err_seen,
                         output logic [15:0] dout_seen);
        @(negedge clk);
        instr       = word;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        lat         = -1;
        err_seen    = 1'b0;
        dout_seen   = '0;
        stall       = (n_stall >= 1);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                lat       = cyc;
                err_seen  = err;
                dout_seen = d_out;
                break;
            end
            @(posedge clk);
            #1;
            stall = ((cyc + 1) <= n_stall);
        end
        stall = 1'b0;
    endtask

    // Runs one instruction and checks latency, err, d_out, the written
    // register, retired, and the return of instr_ready afterwards.
    task automatic run(input string name, input logic [15:0] word, input int n_stall,
                       input int exp_lat, input logic exp_err, input logic [15:0] exp_dout,
                       input logic [RW-1:0] rx, input logic [15:0] exp_reg,
                       input logic [15:0] exp_retired);
        int          lat;
        logic        e;
        logic [15:0] dv;
        issue(word, n_stall, lat, e, dv);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_err"}, e, exp_err);
        check({name, "_d_out"}, dv, exp_dout);
        dbg_addr = rx;
        #1;
        check({name, "_reg"}, dbg_data, exp_reg);
        check({name, "_retired"}, retired, exp_retired);
        @(negedge clk);
        check({name, "_ready_after"}, instr_ready, 1'b1);
        check({name, "_done_single"}, done, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int done_cnt;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_d_out", d_out, 16'h0);
        check("rst_retired", retired, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);

        // 0x20A1: rx=1 imm=5 add imm -> R1 = 5
        run("add_imm_r1", 16'h20A1, 0, 4, 1'b0, 16'h0005, 3'd1, 16'h0005, 16'd1);
        // 0x4061: rx=2 imm=3 add imm -> R2 = 3
        run("add_imm_r2", 16'h4061, 0, 4, 1'b0, 16'h0003, 3'd2, 16'h0003, 16'd2);
        dbg_addr = 3'd1;
        #1;
        check("r1_still_5", dbg_data, 16'h0005);
        // 0x2804: R1 = R1 - R2 = 2
        run("sub_r1", 16'h2804, 0, 4, 1'b0, 16'h0002, 3'd1, 16'h0002, 16'd3);
        // 0x6804: R3 = R3 - R2 = 0 - 3 wraps
        run("sub_wrap_r3", 16'h6804, 0, 4, 1'b0, 16'hFFFD, 3'd3, 16'hFFFD, 16'd4);
        // 0x281C: compare R1=2 with R2=3 -> A<B -> 2, written back to R1
        run("cmp_lt", 16'h281C, 0, 4, 1'b0, 16'h0002, 3'd1, 16'h0002, 16'd5);
        // 0x2803: illegal fmt -> err with done, d_out=0, no writeback
        run("illegal", 16'h2803, 0, 4, 1'b1, 16'h0000, 3'd1, 16'h0002, 16'd5);
        // 0x20A1 with 3 stall cycles in LOAD: R1 = 2 + 5 = 7, done at cycle 7
        run("stall_add", 16'h20A1, 3, 7, 1'b0, 16'h0007, 3'd1, 16'h0007, 16'd6);
        // 0x9FF1: rx=4 imm=0xFF xor -> R4 = 0x00FF
        run("xor_imm_r4", 16'h9FF1, 0, 4, 1'b0, 16'h00FF, 3'd4, 16'h00FF, 16'd7);
        // 0x8095: rx=4 imm=4 shl -> R4 = 0x0FF0
        run("shl_imm_r4", 16'h8095, 0, 4, 1'b0, 16'h0FF0, 3'd4, 16'h0FF0, 16'd8);

        // Reset in CALC: aborted with no writeback and no done.
        done_cnt = 0;
        @(negedge clk);
        instr       = 16'h20A1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_calc", dbg_state, 3'd2);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        for (int r = 0; r < NREGS; r++) begin
            dbg_addr = r[RW-1:0];
            #1;
            check($sformatf("abort_reg%0d", r), dbg_data, 16'h0);
        end
        check("abort_d_out", d_out, 16'h0);
        check("abort_retired", retired, 16'h0);
        check("abort_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_ready", instr_ready, 1'b1);
        dbg_addr = 3'd1;
        #1;
        check("abort_r1_zero", dbg_data, 16'h0);
        check("abort_retired_after", retired, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
